ccr_controller: RTL and testbench

Condition-code controller for the 16-bit pipelined execute stage. It owns the architectural CCR, which holds the flag-valid, carry, negative and zero flags. Each cycle it decides which of the ALU's newStatus bits are committed, based on the ALU operation code. It also evaluates and consumes flags for conditional jumps, and saves/restores the CCR on interrupt entry and RTI through a small shadow stack run by an interrupt-handshake FSM.

---
 rtl/ccr_controller.sv | 146 ++++++++++++++
 tb/tb_ccr_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ccr_controller.sv
// Condition-code controller: owns the architectural CCR {FV,C,N,Z}, applies ALU/flag_op
// updates and jump flag consumption, and saves/restores the CCR around interrupts.
module ccr_controller #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic       ex_stall,
  input  logic       ex_flush,
  input  logic [3:0] alu_ctrl,
  input  logic [3:0] alu_status,
  input  logic [1:0] flag_op,
  input  logic       jmp_valid,
  input  logic [1:0] jmp_cond,
  input  logic       int_req,
  input  logic       rti,
  output logic [3:0] ccr,
  output logic       take_jump,
  output logic       int_ack,
  output logic       save_overflow,
  output logic       restore_underflow
);

  localparam int CW = $clog2(SHADOW_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SHADOW_DEPTH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] count;
  logic [3:0]    stack [SHADOW_DEPTH];
  logic [3:0]    upd_val, ccr_nxt, stack_top;
  logic          upd, flag_none, upd_c, upd_nz, cond, pop_req, push_req;
  logic          status_unused;

  // Bit 3 of alu_status is a constant 1 from the ALU; FV is generated here instead.
  assign status_unused = alu_status[3];

  assign upd       = ex_valid & ~ex_stall & ~ex_flush;
  assign flag_none = (flag_op == 2'b00) || (flag_op == 2'b11);

  always_comb begin
    upd_c  = 1'b0;
    upd_nz = 1'b0;
    case (alu_ctrl)
      4'b0010, 4'b0011, 4'b0110: upd_nz = 1'b1;
      4'b0111, 4'b1010: ;
      default: begin
        upd_c  = 1'b1;
        upd_nz = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (jmp_cond)
      2'b00:   cond = ccr[0];
      2'b01:   cond = ccr[1];
      2'b10:   cond = ccr[2];
      default: cond = 1'b1;
    endcase
  end

  assign take_jump = jmp_valid & ~ex_stall & cond;
  assign pop_req   = (state == ST_RUN) & rti & ~ex_stall;
  assign push_req  = (state == ST_RUN) & int_req & ~ex_stall & ~rti;

  always_comb begin
    stack_top = stack[0];
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (CW'(i + 1) == count) stack_top = stack[i];
    end
  end

  // Jump clear is applied first so a same-cycle ALU/flag_op write overrides it.
  always_comb begin
    upd_val = ccr;
    if (take_jump) begin
      case (jmp_cond)
        2'b00:   upd_val[0] = 1'b0;
        2'b01:   upd_val[1] = 1'b0;
        2'b10:   upd_val[2] = 1'b0;
        default: ;
      endcase
    end
    if (upd) begin
      if (!flag_none) begin
        upd_val[3] = 1'b1;
        upd_val[2] = (flag_op == 2'b01);
      end else begin
        if (upd_c) upd_val[2] = alu_status[2];
        if (upd_nz) begin
          upd_val[1:0] = alu_status[1:0];
          upd_val[3]   = 1'b1;
        end
      end
    end
    ccr_nxt = upd_val;
    if (pop_req) ccr_nxt = (count != '0) ? stack_top : ccr;
  end

  // ACK always advances so int_ack stays exactly one cycle wide, even under stall.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (push_req) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_WAIT;
      ST_WAIT: if (!int_req && !ex_stall) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr               <= 4'b0000;
      state             <= ST_RUN;
      count             <= '0;
      int_ack           <= 1'b0;
      save_overflow     <= 1'b0;
      restore_underflow <= 1'b0;
      for (int i = 0; i < SHADOW_DEPTH; i++) stack[i] <= 4'b0000;
    end else begin
      ccr     <= ccr_nxt;
      state   <= state_nxt;
      int_ack <= push_req;
      if (push_req) begin
        if (count == FULL) begin
          save_overflow <= 1'b1;
        end else begin
          for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (CW'(i) == count) stack[i] <= ccr_nxt;
          end
          count <= count + CW'(1);
        end
      end
      if (pop_req) begin
        if (count == '0) restore_underflow <= 1'b1;
        else count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ccr_controller.sv
// Directed bench for ccr_controller: a behavioural CCR/stack model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_ccr_controller;

  localparam int DEPTH = 2;

  logic       clk, rst_n;
  logic       ex_valid, ex_stall, ex_flush;
  logic [3:0] alu_ctrl, alu_status;
  logic [1:0] flag_op, jmp_cond;
  logic       jmp_valid, int_req, rti;
  logic [3:0] ccr;
  logic       take_jump, int_ack, save_overflow, restore_underflow;

  int total = 0;
  int bad   = 0;

  ccr_controller #(.SHADOW_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .alu_ctrl(alu_ctrl), .alu_status(alu_status),
    .flag_op(flag_op), .jmp_valid(jmp_valid), .jmp_cond(jmp_cond),
    .int_req(int_req), .rti(rti), .ccr(ccr), .take_jump(take_jump),
    .int_ack(int_ack), .save_overflow(save_overflow),
    .restore_underflow(restore_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: expected CCR, expected shadow stack, interrupt phase
  logic [3:0] m_ccr, nv;
  logic [3:0] exp_q[$];
  int         m_phase;  // 0 running, 1 acknowledging, 2 waiting for int_req low
  logic       m_ack, m_ovf, m_unf, exp_tj, m_cond;
  bit         full_upd, nz_upd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ccr = 4'b0000; exp_q.delete(); m_phase = 0;
      m_ack = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      check("rst_ccr", ccr, 4'b0000);
      check("rst_ack", {3'b0, int_ack}, 4'b0000);
      check("rst_sticky", {2'b0, save_overflow, restore_underflow}, 4'b0000);
    end else begin
      check("ccr", ccr, m_ccr);
      check("int_ack", {3'b0, int_ack}, {3'b0, m_ack});
      check("save_overflow", {3'b0, save_overflow}, {3'b0, m_ovf});
      check("restore_underflow", {3'b0, restore_underflow}, {3'b0, m_unf});
      m_cond = (jmp_cond == 2'b11) ? 1'b1 : m_ccr[jmp_cond];
      exp_tj = jmp_valid && !ex_stall && m_cond;
      check("take_jump", {3'b0, take_jump}, {3'b0, exp_tj});

      nv = m_ccr;
      if (exp_tj && jmp_cond != 2'b11) nv[jmp_cond] = 1'b0;
      if (ex_valid && !ex_stall && !ex_flush) begin
        if (flag_op == 2'b01) nv[3:2] = 2'b11;
        else if (flag_op == 2'b10) nv[3:2] = 2'b10;
        else begin
          full_upd = alu_ctrl inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, [4'd11:4'd15]};
          nz_upd   = alu_ctrl inside {4'd2, 4'd3, 4'd6};
          if (full_upd) nv = {1'b1, alu_status[2:0]};
          if (nz_upd)   nv = {1'b1, nv[2], alu_status[1:0]};
        end
      end
      m_ack = 1'b0;
      if (m_phase == 0 && !ex_stall && rti) begin
        if (exp_q.size() > 0) nv = exp_q.pop_back();
        else begin nv = m_ccr; m_unf = 1'b1; end
      end else if (m_phase == 0 && !ex_stall && int_req) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(nv);
        else m_ovf = 1'b1;
        m_phase = 1; m_ack = 1'b1;
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && !ex_stall && !int_req) m_phase = 0;
      m_ccr = nv;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_stall = 0; ex_flush = 0; alu_ctrl = 0; alu_status = 0;
    flag_op = 0; jmp_valid = 0; jmp_cond = 0; int_req = 0; rti = 0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [3:0] st);
    ex_valid = 1; alu_ctrl = op; alu_status = st;
    step();
    ex_valid = 0;
  endtask

  task automatic irq_cycle();
    int_req = 1; step();
    check("lit_ack_pulse", {3'b0, int_ack}, 4'b0001);
    int_req = 0; step();
    check("lit_ack_width", {3'b0, int_ack}, 4'b0000);
    step();
  endtask

  task automatic rti_pulse();
    rti = 1; step(); rti = 0; step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
    check("lit_reset", ccr, 4'b0000);

    alu(4'b0000, 4'b0101); check("lit_add", ccr, 4'b1101);
    alu(4'b0010, 4'b1010); check("lit_and_hold_c", ccr, 4'b1110);
    alu(4'b0111, 4'b1001); check("lit_pass", ccr, 4'b1110);
    ex_flush = 1; alu(4'b0000, 4'b0001); ex_flush = 0;
    check("lit_flush", ccr, 4'b1110);
    ex_stall = 1; jmp_valid = 1; jmp_cond = 2'b11; ex_valid = 1;
    alu_ctrl = 4'b0000; alu_status = 4'b0001; #1;
    check("lit_stall_tj", {3'b0, take_jump}, 4'b0000);
    step(); idle();
    check("lit_stall", ccr, 4'b1110);

    ex_valid = 1; flag_op = 2'b10; alu_ctrl = 4'b0000; alu_status = 4'b0111;
    step(); check("lit_clrc", ccr, 4'b1010);
    flag_op = 2'b01; step(); check("lit_setc", ccr, 4'b1110);
    idle(); flag_op = 2'b01; step(); check("lit_setc_noupd", ccr, 4'b1110);
    idle();

    alu(4'b0001, 4'b0001); check("lit_sub", ccr, 4'b1001);
    jmp_valid = 1; jmp_cond = 2'b00; #1;
    check("lit_jz_taken", {3'b0, take_jump}, 4'b0001);
    step(); check("lit_jz_clear", ccr, 4'b1000);
    jmp_cond = 2'b10; #1;
    check("lit_jc_not", {3'b0, take_jump}, 4'b0000);
    step();
    jmp_cond = 2'b11; #1;
    check("lit_jmp", {3'b0, take_jump}, 4'b0001);
    step(); idle();
    check("lit_jmp_noclr", ccr, 4'b1000);

    alu(4'b0001, 4'b0001);
    jmp_valid = 1; jmp_cond = 2'b00;
    alu(4'b0000, 4'b1001); idle();
    check("lit_alu_over_jclr", ccr, 4'b1001);

    alu(4'b0000, 4'b0110); check("lit_pre_irq", ccr, 4'b1110);
    irq_cycle();
    alu(4'b0001, 4'b1001); check("lit_isr_sub", ccr, 4'b1001);
    rti_pulse(); check("lit_rti", ccr, 4'b1110);

    alu(4'b0000, 4'b0001); irq_cycle();
    alu(4'b0000, 4'b0010); irq_cycle();
    check("lit_no_ovf", {3'b0, save_overflow}, 4'b0000);
    alu(4'b0000, 4'b0100); irq_cycle();
    check("lit_ovf", {3'b0, save_overflow}, 4'b0001);
    rti_pulse(); check("lit_pop1", ccr, 4'b1010);
    rti_pulse(); check("lit_pop2", ccr, 4'b1001);
    check("lit_no_unf", {3'b0, restore_underflow}, 4'b0000);
    alu(4'b0000, 4'b0111);
    rti_pulse(); check("lit_unf_hold", ccr, 4'b1111);
    check("lit_unf", {3'b0, restore_underflow}, 4'b0001);

    rti = 1; int_req = 1; step(); rti = 0; step();
    check("lit_ack_after_rti", {3'b0, int_ack}, 4'b0001);
    int_req = 0; step(); step();

    for (int i = 0; i < 16; i++) begin
      jmp_valid = 1; jmp_cond = 2'(i);
      alu(4'(i), 4'(i) ^ 4'b0101);
    end
    idle(); step();

    int_req = 1; step();
    check("lit_ack_mid", {3'b0, int_ack}, 4'b0001);
    #1 rst_n = 0;
    #1 check("lit_async_ack", {3'b0, int_ack}, 4'b0000);
    check("lit_async_ccr", ccr, 4'b0000);
    int_req = 0;
    step(); rst_n = 1;
    step(); step();
    check("lit_post_reset", ccr, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
